// File: rtl/core_pkg.sv
// Shared core-level constants and the handshake-op encoding used by the instruction queue.
package core_pkg;

    localparam int INSTR_W  = 44;
    localparam int IQ_DEPTH = 8;

    // One bit per side of the FIFO: {push, pop}
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-around index register for a circular buffer; clr has priority over inc.
module fifo_ptr #(
    parameter  int DEPTH = 8,
    localparam int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          inc_i,
    output logic [PW-1:0] ptr_o
);

    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/instr_fifo.sv
// Circular-buffer instruction queue between decode and issue, valid/ready on both sides,
// with flush, occupancy/almost-full reporting and sticky overflow/underflow flags.
module instr_fifo
    import core_pkg::*;
#(
    parameter  int WIDTH    = INSTR_W,
    parameter  int DEPTH    = IQ_DEPTH,
    parameter  int AF_LEVEL = DEPTH - 2,
    localparam int CW       = $clog2(DEPTH + 1),
    localparam int PW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full,
    output logic             err_overflow,
    output logic             err_underflow,
    input  logic             err_clr
);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             err_overflow_q;
    logic             err_overflow_d;
    logic             err_underflow_q;
    logic             err_underflow_d;

    logic             push;
    logic             pop;
    logic             ovf_evt;
    logic             udf_evt;
    fifo_op_e         op;

    // A pop at full frees the slot in the same cycle, so in_ready looks only at out_ready.
    assign in_ready  = (count_q != DEPTH_C) | out_ready;
    assign out_valid = (count_q != '0);

    // Everything offered during a flush is discarded, including error detection.
    assign push    = in_valid & in_ready & ~flush;
    assign pop     = out_valid & out_ready & ~flush;
    assign ovf_evt = in_valid & ~in_ready & ~flush;
    assign udf_evt = out_ready & ~out_valid & ~flush;
    assign op      = fifo_op_e'({push, pop});

    fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (pop),
        .ptr_o (rd_ptr)
    );

    fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr_i (flush),
        .inc_i (push),
        .ptr_o (wr_ptr)
    );

    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else begin
            unique case (op)
                OP_PUSH: count_d = count_q + 1'b1;
                OP_POP:  count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // A fresh error event in the clearing cycle wins over err_clr.
    always_comb begin
        err_overflow_d  = ovf_evt | (err_overflow_q & ~err_clr);
        err_underflow_d = udf_evt | (err_underflow_q & ~err_clr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q         <= '0;
            err_overflow_q  <= 1'b0;
            err_underflow_q <= 1'b0;
        end else begin
            count_q         <= count_d;
            err_overflow_q  <= err_overflow_d;
            err_underflow_q <= err_underflow_d;
        end
    end

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= in_data;
        end
    end

    // Head is read from registered storage, so a same-cycle write at full still shows the old head.
    assign out_data      = mem_q[rd_ptr];
    assign count         = count_q;
    assign almost_full   = (count_q >= AF_C);
    assign err_overflow  = err_overflow_q;
    assign err_underflow = err_underflow_q;

endmodule

// File: tb/tb_instr_fifo.sv
// Self-checking bench for instr_fifo: table vectors, hand-written corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_instr_fifo;
    import core_pkg::*;

    localparam int W  = INSTR_W;
    localparam int D  = IQ_DEPTH;
    localparam int AF = IQ_DEPTH - 2;
    localparam int CW = $clog2(D + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic          err_clr = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready;
    logic          out_valid;
    logic [W-1:0]  out_data;
    logic [CW-1:0] count;
    logic          almost_full;
    logic          err_overflow;
    logic          err_underflow;

    instr_fifo #(.WIDTH(W), .DEPTH(D), .AF_LEVEL(AF)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_data       (in_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .count         (count),
        .almost_full   (almost_full),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_clr       (err_clr)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model: the FIFO contents as a plain queue, plus the two sticky flags.
    logic [W-1:0] mq[$];
    bit           m_ovf = 1'b0;
    bit           m_udf = 1'b0;

    typedef struct {
        bit           iv;
        logic [W-1:0] din;
        bit           ordy;
        bit           fl;
        bit           ec;
        int           e_cnt;
        bit           e_rdy;
        bit           e_vld;
        logic [W-1:0] e_data;
        bit           e_af;
        bit           e_ovf;
        bit           e_udf;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit exp_rdy;
        bit exp_vld;
        exp_rdy = (mq.size() < D) || (out_ready == 1'b1);
        exp_vld = (mq.size() != 0);
        chk({tag, ".in_ready"},  64'(in_ready),  64'(exp_rdy));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(exp_vld));
        chk({tag, ".count"},     64'(count),     64'(mq.size()));
        chk({tag, ".af"},        64'(almost_full), 64'(mq.size() >= AF));
        chk({tag, ".ovf"},       64'(err_overflow),  64'(m_ovf));
        chk({tag, ".udf"},       64'(err_underflow), 64'(m_udf));
        if (exp_vld) chk({tag, ".out_data"}, 64'(out_data), 64'(mq[0]));
    endtask

    task automatic model_step();
        bit rdy;
        bit vld;
        bit ov;
        bit ud;
        rdy = (mq.size() < D) || (out_ready == 1'b1);
        vld = (mq.size() != 0);
        if (flush) begin
            mq.delete();
            if (err_clr) begin
                m_ovf = 1'b0;
                m_udf = 1'b0;
            end
        end else begin
            ov = in_valid && !rdy;
            ud = out_ready && !vld;
            if (vld && out_ready) void'(mq.pop_front());
            if (in_valid && rdy) mq.push_back(in_data);
            m_ovf = ov | (m_ovf & ~err_clr);
            m_udf = ud | (m_udf & ~err_clr);
        end
    endtask

    // One clock of traffic: inputs applied 2 time units after the edge, checked 1 unit later.
    task automatic drive(input bit iv, input logic [W-1:0] din, input bit ordy,
                         input bit fl, input bit ec, input string tag);
        in_valid  = iv;
        in_data   = din;
        out_ready = ordy;
        flush     = fl;
        err_clr   = ec;
        #1;
        check_model(tag);
        model_step();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        err_clr   = 1'b0;
        #1;
        $display("txn %s iv=%0b din=%h ordy=%0b fl=%0b clr=%0b -> count=%0d vld=%0b ovf=%0b udf=%0b",
                 tag, iv, din, ordy, fl, ec, count, out_valid, err_overflow, err_underflow);
    endtask

    function automatic vec_t mk(input bit iv, input int din, input bit ordy, input bit fl,
                                input bit ec, input int e_cnt, input bit e_rdy, input bit e_vld,
                                input int e_data, input bit e_af, input bit e_ovf, input bit e_udf);
        vec_t v;
        v.iv = iv;   v.din = W'(din); v.ordy = ordy; v.fl = fl; v.ec = ec;
        v.e_cnt = e_cnt; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_data = W'(e_data);
        v.e_af = e_af; v.e_ovf = e_ovf; v.e_udf = e_udf;
        return v;
    endfunction

    initial begin
        logic [63:0] r;

        // Reset state while rst is held low.
        #1;
        chk("rst.in_ready",  64'(in_ready),      64'(1));
        chk("rst.out_valid", 64'(out_valid),     64'(0));
        chk("rst.count",     64'(count),         64'(0));
        chk("rst.af",        64'(almost_full),   64'(0));
        chk("rst.ovf",       64'(err_overflow),  64'(0));
        chk("rst.udf",       64'(err_underflow), 64'(0));
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #2;

        // Fill, overflow, clear, drain, underflow, clear. Post-edge state seen with idle inputs.
        for (int k = 1; k <= 8; k++) vt.push_back(mk(1, k, 0, 0, 0, k, k < 8, 1, 1, k >= 6, 0, 0));
        vt.push_back(mk(1, 9, 0, 0, 0, 8, 0, 1, 1, 1, 1, 0));
        vt.push_back(mk(0, 0, 0, 0, 1, 8, 0, 1, 1, 1, 0, 0));
        for (int k = 1; k <= 8; k++) vt.push_back(mk(0, 0, 1, 0, 0, 8 - k, 1, k < 8, k + 1, (8 - k) >= 6, 0, 0));
        vt.push_back(mk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 1));
        vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0));

        foreach (vt[i]) begin
            drive(vt[i].iv, vt[i].din, vt[i].ordy, vt[i].fl, vt[i].ec, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.count", i),    64'(count),         64'(vt[i].e_cnt));
            chk($sformatf("vec%0d.in_ready", i), 64'(in_ready),      64'(vt[i].e_rdy));
            chk($sformatf("vec%0d.out_valid", i),64'(out_valid),     64'(vt[i].e_vld));
            chk($sformatf("vec%0d.af", i),       64'(almost_full),   64'(vt[i].e_af));
            chk($sformatf("vec%0d.ovf", i),      64'(err_overflow),  64'(vt[i].e_ovf));
            chk($sformatf("vec%0d.udf", i),      64'(err_underflow), 64'(vt[i].e_udf));
            if (vt[i].e_vld) chk($sformatf("vec%0d.out_data", i), 64'(out_data), 64'(vt[i].e_data));
        end

        // Full-rate push+pop at full: old head is shown, count stays at DEPTH.
        for (int k = 1; k <= 8; k++) drive(1, W'(k), 0, 0, 0, "fill");
        in_valid = 1'b1; in_data = W'(12'h0AA); out_ready = 1'b1;
        #1;
        chk("full_rate.in_ready", 64'(in_ready), 64'(1));
        chk("full_rate.head",     64'(out_data), 64'(1));
        drive(1, W'(12'h0AA), 1, 0, 0, "full_rate");
        chk("full_rate.count", 64'(count), 64'(8));
        for (int k = 0; k < 8; k++) begin
            out_ready = 1'b1;
            #1;
            chk($sformatf("full_drain%0d", k), 64'(out_data), (k < 7) ? 64'(k + 2) : 64'h0AA);
            drive(0, '0, 1, 0, 0, "full_drain");
        end
        chk("full_drain.count", 64'(count), 64'(0));

        // Wrap-around: push 5, pop 5, push 8, read 8 back in order.
        for (int k = 1; k <= 5; k++) drive(1, W'(12'h100 + k), 0, 0, 0, "wrap_push_a");
        for (int k = 1; k <= 5; k++) drive(0, '0, 1, 0, 0, "wrap_pop_a");
        for (int k = 1; k <= 8; k++) drive(1, W'(12'h200 + k), 0, 0, 0, "wrap_push_b");
        for (int k = 1; k <= 8; k++) begin
            out_ready = 1'b1;
            #1;
            chk($sformatf("wrap_read%0d", k), 64'(out_data), 64'(12'h200 + k));
            drive(0, '0, 1, 0, 0, "wrap_pop_b");
        end
        chk("wrap.count",     64'(count),     64'(0));
        chk("wrap.out_valid", 64'(out_valid), 64'(0));

        // Flush with push and pop in the same cycle at count=4.
        for (int k = 1; k <= 4; k++) drive(1, W'(12'h300 + k), 0, 0, 0, "pre_flush");
        drive(1, W'(12'h3FF), 1, 1, 0, "flush");
        chk("flush.count",     64'(count),         64'(0));
        chk("flush.out_valid", 64'(out_valid),     64'(0));
        chk("flush.ovf",       64'(err_overflow),  64'(0));
        chk("flush.udf",       64'(err_underflow), 64'(0));
        drive(0, '0, 1, 1, 0, "flush_empty_pop");
        chk("flush_empty.udf", 64'(err_underflow), 64'(0));
        drive(1, W'(12'h3AB), 0, 0, 0, "post_flush");
        chk("post_flush.data",  64'(out_data), 64'(12'h3AB));
        chk("post_flush.count", 64'(count),    64'(1));
        drive(0, '0, 1, 0, 0, "post_flush_pop");

        // err_clr colliding with a fresh overflow keeps the flag set.
        for (int k = 1; k <= 8; k++) drive(1, W'(12'h400 + k), 0, 0, 0, "fill_ovf");
        drive(1, W'(12'h4FF), 0, 0, 0, "ovf_set");
        chk("ovf_set", 64'(err_overflow), 64'(1));
        drive(1, W'(12'h4FE), 0, 0, 1, "ovf_collide");
        chk("ovf_collide", 64'(err_overflow), 64'(1));
        drive(0, '0, 0, 0, 1, "ovf_clear");
        chk("ovf_clear", 64'(err_overflow), 64'(0));
        drive(0, '0, 0, 1, 0, "flush_after_ovf");

        // Asynchronous reset mid-stream at count=3, asserted between edges.
        drive(0, '0, 1, 0, 0, "udf_before_rst");
        for (int k = 1; k <= 3; k++) drive(1, W'(12'h500 + k), 0, 0, 0, "pre_rst");
        #1;
        rst = 1'b0;
        #1;
        chk("arst.count",     64'(count),         64'(0));
        chk("arst.out_valid", 64'(out_valid),     64'(0));
        chk("arst.in_ready",  64'(in_ready),      64'(1));
        chk("arst.udf",       64'(err_underflow), 64'(0));
        mq.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        drive(1, W'(12'h5AA), 0, 0, 0, "post_rst");
        chk("post_rst.data",  64'(out_data), 64'(12'h5AA));
        chk("post_rst.count", 64'(count),    64'(1));

        // Randomized traffic: producer-heavy phase first, then consumer-heavy.
        for (int c = 0; c < 600; c++) begin
            int piv;
            int prdy;
            piv  = (c < 300) ? 75 : 35;
            prdy = (c < 300) ? 35 : 75;
            r = {$urandom, $urandom};
            drive($urandom_range(0, 99) < piv, r[W-1:0], $urandom_range(0, 99) < prdy,
                  $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 5, "rand");
        end
        #1;
        check_model("final");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
